// File: rtl/de0_onchip_ram_pipelined_pkg.sv
// Shared definitions for the pipelined on-chip RAM: controller state
// encoding, the read-latency ceiling and the parameter legality check.
package de0_onchip_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int MAX_READ_LATENCY = 3;

    // True when the parameter set describes a buildable RAM.
    function automatic bit params_ok(
        input int data_w,
        input int addr_w,
        input int depth,
        input int read_latency
    );
        return (data_w >= 8) && (data_w % 8 == 0) &&
               (addr_w >= 1) && (addr_w < 31) &&
               (depth >= 2) && (depth <= (1 << addr_w)) &&
               (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/de0_onchip_ram_pipelined_if.sv
// Avalon-MM s1-style slave bus between the interconnect and the RAM.
interface de0_onchip_ram_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/de0_ram_core.sv
// DEPTH x DATA_W storage with per-byte write enables, a registered read
// index and an asynchronous array read, so data follows one cycle after
// the read is accepted.
module de0_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [DATA_W/8-1:0] i_wr_be,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_rd_en,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [DATA_W-1:0]   o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [IDX_W-1:0]  r_rd_idx;

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    // NOTE: the array has no reset branch -- resetting every word would stop
    // the tools from mapping it onto block RAM; zero-fill is done by writes.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (i_wr_be[i]) begin
                    r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Capture the read index when a read is accepted; hold it otherwise.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_idx <= '0;
        end else if (i_rd_en) begin
            r_rd_idx <= i_rd_idx;
        end
    end

    assign o_rd_data = r_mem[r_rd_idx];

endmodule

// File: rtl/de0_onchip_ram_pipelined.sv
// Parametrised single-port Avalon-MM on-chip RAM: zero-fill after reset,
// waitrequest stalling, pipelined reads with readdatavalid, clock enable
// freeze and a sticky out-of-range flag.
module de0_onchip_ram_pipelined
    import de0_onchip_ram_pkg::*;
#(
    parameter int    DATA_W         = 32,
    parameter int    ADDR_W         = 15,
    parameter int    DEPTH          = 32000,
    parameter int    READ_LATENCY   = 2,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    de0_onchip_ram_pipelined_if.slave s1,
    output logic init_busy,
    output logic range_err
);

    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    if (!params_ok(DATA_W, ADDR_W, DEPTH, READ_LATENCY)) begin : g_bad_params
        $error("de0_onchip_ram_pipelined: illegal DATA_W/ADDR_W/DEPTH/READ_LATENCY");
    end

    if ((INIT_FILE != "") && !CLEAR_ON_RESET) begin : g_init_file
        $warning("de0_onchip_ram_pipelined: INIT_FILE contents must be loaded by the target memory initialisation flow");
    end

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic                r_range_err;
    logic                r_rd_valid0, r_rd_oor0;

    logic                w_clearing, w_wait, w_req, w_oor;
    logic                w_wr_acc, w_rd_acc;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_idx;
    logic [DATA_W/8-1:0] w_mem_be;
    logic [DATA_W-1:0]   w_mem_data;
    logic [DATA_W-1:0]   w_core_q, w_s0_data;

    assign w_clearing     = (r_state == ST_CLEAR);
    assign w_wait         = w_clearing | ~clken;
    assign s1.waitrequest = w_wait;
    assign init_busy      = w_clearing;
    assign range_err      = r_range_err;

    assign w_req    = s1.chipselect & (s1.read | s1.write) & ~w_wait;
    assign w_oor    = ({1'b0, s1.address} >= DEPTH_X);
    assign w_wr_acc = w_req & s1.write;
    // A simultaneous write wins; the read half is dropped.
    assign w_rd_acc = w_req & s1.read & ~s1.write;

    // Controller state and zero-fill address register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RESET_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next state: walk the fill address once per enabled cycle, then go ready.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        unique case (r_state)
            ST_CLEAR: begin
                if (clken) begin
                    if (r_clr_addr == LAST_ADDR) begin
                        w_state_nxt    = ST_READY;
                        w_clr_addr_nxt = '0;
                    end else begin
                        w_clr_addr_nxt = r_clr_addr + 1'b1;
                    end
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    // Write port mux: zero-fill owns the RAM while clearing, the bus otherwise.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_idx  = s1.address[IDX_W-1:0];
        w_mem_be   = s1.byteenable;
        w_mem_data = s1.writedata;
        if (w_clearing) begin
            w_mem_we   = clken;
            w_mem_idx  = r_clr_addr[IDX_W-1:0];
            w_mem_be   = '1;
            w_mem_data = '0;
        end else begin
            w_mem_we   = w_wr_acc & ~w_oor;
        end
    end

    de0_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_we      (w_mem_we),
        .i_wr_idx  (w_mem_idx),
        .i_wr_be   (w_mem_be),
        .i_wr_data (w_mem_data),
        .i_rd_en   (w_rd_acc & ~w_oor),
        .i_rd_idx  (s1.address[IDX_W-1:0]),
        .o_rd_data (w_core_q)
    );

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_range_err <= 1'b0;
        end else if (w_req && w_oor) begin
            r_range_err <= 1'b1;
        end
    end

    // First read stage: tracks the RAM's one-cycle read and whether it was out of range.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid0 <= 1'b0;
            r_rd_oor0   <= 1'b0;
        end else if (clken) begin
            r_rd_valid0 <= w_rd_acc;
            r_rd_oor0   <= w_rd_acc & w_oor;
        end
    end

    // Out-of-range reads and idle cycles present zero data.
    assign w_s0_data = (r_rd_valid0 && !r_rd_oor0) ? w_core_q : '0;

    if (READ_LATENCY == 1) begin : g_lat1
        assign s1.readdata      = w_s0_data;
        assign s1.readdatavalid = r_rd_valid0;
    end else begin : g_pipe
        logic [DATA_W-1:0]       r_pipe_data [0:READ_LATENCY-2];
        logic [READ_LATENCY-2:0] r_pipe_valid;

        // Extra latency stages; a frozen clken holds any pending result in place.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pipe_valid <= '0;
                for (int k = 0; k < READ_LATENCY - 1; k++) begin
                    r_pipe_data[k] <= '0;
                end
            end else if (clken) begin
                r_pipe_valid[0] <= r_rd_valid0;
                r_pipe_data[0]  <= w_s0_data;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    r_pipe_valid[k] <= r_pipe_valid[k-1];
                    r_pipe_data[k]  <= r_pipe_data[k-1];
                end
            end
        end

        assign s1.readdata      = r_pipe_data[READ_LATENCY-2];
        assign s1.readdatavalid = r_pipe_valid[READ_LATENCY-2];
    end

    a_rd_wr_collision: assert property (
        @(posedge clk) disable iff (!reset_n) !(w_req && s1.read && s1.write)
    );

endmodule

// File: tb/tb_de0_onchip_ram_pipelined.sv
// Directed bench for de0_onchip_ram_pipelined with DEPTH=16, READ_LATENCY=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_de0_onchip_ram_pipelined;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic init_busy;
    logic range_err;

    int checks   = 0;
    int failures = 0;

    de0_onchip_ram_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    de0_onchip_ram_pipelined #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .DEPTH          (DEPTH),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("")
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .s1        (bus),
        .init_busy (init_busy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_data;
        bit          exp_range_err;
    } vec_t;

    typedef struct {
        bit          ce;
        bit          rd;
        logic [4:0]  addr;
        bit          exp_v;
        logic [31:0] exp_d;
    } step_t;

    vec_t  vecs[$];
    step_t steps[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
    endtask

    // Called just after reset_n rises, before the next rising edge: the fill
    // must stall the bus for exactly DEPTH enabled cycles.
    task automatic expect_fill(input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s busy c%0d", nm, i), init_busy, 1'b1);
            check($sformatf("%s wait c%0d", nm, i), bus.waitrequest, 1'b1);
            @(negedge clk);
        end
        check({nm, " busy done"}, init_busy, 1'b0);
        check({nm, " wait done"}, bus.waitrequest, 1'b0);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                            input string nm);
        check({nm, " wait"}, bus.waitrequest, 1'b0);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string nm);
        check({nm, " wait"}, bus.waitrequest, 1'b0);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus_idle();
        for (int k = 1; k < RL; k++) begin
            check($sformatf("%s early valid %0d", nm, k), bus.readdatavalid, 1'b0);
            @(negedge clk);
        end
        check({nm, " valid"}, bus.readdatavalid, 1'b1);
        check({nm, " data"}, bus.readdata, exp);
        @(negedge clk);
        check({nm, " single pulse"}, bus.readdatavalid, 1'b0);
    endtask

    initial begin
        logic [31:0] seq_exp [0:3];
        bit          exp_v;

        reset_n = 1'b0;
        clken   = 1'b1;
        bus_idle();

        // Transactions after the fill; lanes with byteenable set take new bytes.
        vecs.push_back('{1'b0, 5'd5,  32'h0,          4'h0, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 5'd3,  32'h1122_3344,  4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 5'd3,  32'hDEAD_BEEF,  4'h5, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 5'd3,  32'h0,          4'h0, 32'h11AD_33EF, 1'b0});
        vecs.push_back('{1'b1, 5'd0,  32'hA0A0_A0A0,  4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 5'd1,  32'h0123_4567,  4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 5'd2,  32'hCAFE_F00D,  4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 5'd2,  32'hFFFF_FFFF,  4'h0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 5'd2,  32'h0,          4'h0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b1, 5'd1,  32'hAABB_CCDD,  4'h8, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 5'd1,  32'h0,          4'h0, 32'hAA23_4567, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,          4'h0, 32'hA0A0_A0A0, 1'b0});
        vecs.push_back('{1'b1, 5'd16, 32'h5555_5555,  4'hF, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 5'd16, 32'h0,          4'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,          4'h0, 32'hA0A0_A0A0, 1'b1});
        vecs.push_back('{1'b0, 5'd15, 32'h0,          4'h0, 32'h0000_0000, 1'b1});

        // clken freeze with a result pending: held, then resumes without loss.
        steps.push_back('{1'b1, 1'b1, 5'd0, 1'b0, 32'h0});
        steps.push_back('{1'b1, 1'b1, 5'd1, 1'b1, 32'hA0A0_A0A0});
        steps.push_back('{1'b0, 1'b1, 5'd2, 1'b1, 32'hA0A0_A0A0});
        steps.push_back('{1'b0, 1'b1, 5'd2, 1'b1, 32'hA0A0_A0A0});
        steps.push_back('{1'b0, 1'b1, 5'd2, 1'b1, 32'hA0A0_A0A0});
        steps.push_back('{1'b1, 1'b1, 5'd2, 1'b1, 32'hAA23_4567});
        steps.push_back('{1'b1, 1'b1, 5'd3, 1'b1, 32'hCAFE_F00D});
        steps.push_back('{1'b1, 1'b0, 5'd0, 1'b1, 32'h11AD_33EF});
        steps.push_back('{1'b1, 1'b0, 5'd0, 1'b0, 32'h0});

        // Reset values.
        #12;
        check("rst readdata", bus.readdata, 32'h0);
        check("rst readdatavalid", bus.readdatavalid, 1'b0);
        check("rst range_err", range_err, 1'b0);
        check("rst waitrequest", bus.waitrequest, 1'b1);
        check("rst init_busy", init_busy, 1'b1);

        // Zero-fill after reset.
        @(negedge clk);
        reset_n = 1'b1;
        expect_fill("fill");

        // Table-driven single transactions.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].be, $sformatf("vec%0d wr", i));
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_data, $sformatf("vec%0d rd", i));
            end
            check($sformatf("vec%0d range_err", i), range_err, vecs[i].exp_range_err);
        end

        // Back-to-back reads of 0..3: valids on four consecutive cycles from +2.
        seq_exp[0] = 32'hA0A0_A0A0;
        seq_exp[1] = 32'hAA23_4567;
        seq_exp[2] = 32'hCAFE_F00D;
        seq_exp[3] = 32'h11AD_33EF;
        for (int t = 0; t < 7; t++) begin
            if (t >= 1) begin
                exp_v = (t >= 2) && (t <= 5);
                check($sformatf("b2b valid t%0d", t), bus.readdatavalid, exp_v);
                if (exp_v) begin
                    check($sformatf("b2b data t%0d", t), bus.readdata, seq_exp[t-2]);
                end
            end
            if (t < 4) begin
                bus.chipselect = 1'b1;
                bus.read       = 1'b1;
                bus.address    = 5'(t);
            end else begin
                bus_idle();
            end
            @(negedge clk);
        end

        // Clock-enable freeze in mid-pipeline.
        for (int t = 0; t < steps.size(); t++) begin
            clken          = steps[t].ce;
            bus.chipselect = steps[t].rd;
            bus.read       = steps[t].rd;
            bus.address    = steps[t].addr;
            if (!steps[t].ce) begin
                #1;
                check($sformatf("freeze wait t%0d", t), bus.waitrequest, 1'b1);
            end
            @(negedge clk);
            check($sformatf("freeze valid t%0d", t), bus.readdatavalid, steps[t].exp_v);
            if (steps[t].exp_v) begin
                check($sformatf("freeze data t%0d", t), bus.readdata, steps[t].exp_d);
            end
        end
        clken = 1'b1;
        bus_idle();
        check("range_err sticky", range_err, 1'b1);

        // Reset in the middle of the fill restarts it from address 0.
        do_write(5'd15, 32'h1234_5678, 4'hF, "pre-reset wr");
        reset_n = 1'b0;
        #1;
        check("reset clears range_err", range_err, 1'b0);
        check("reset busy", init_busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            check($sformatf("half fill busy c%0d", i), init_busy, 1'b1);
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("mid-fill reset busy", init_busy, 1'b1);
        #1;
        reset_n = 1'b1;
        expect_fill("refill");
        do_read(5'd15, 32'h0, "refill rd15");
        do_read(5'd3, 32'h0, "refill rd3");
        check("refill range_err", range_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
